// File: rtl/bt_cmd_seq.sv
// rtl/bt_cmd_seq.sv - BT module command sequencer: power-up delay, banner wait, init commands, button commands.
module bt_cmd_seq #(
  parameter int WAIT_W    = 17,
  parameter int TMO_W     = 20,
  parameter int MAX_RETRY = 2,
  parameter int N_INIT    = 2,
  parameter int N_BTN     = 2,
  parameter logic [5*N_INIT-1:0] INIT_START = {5'd6, 5'd0},
  parameter logic [4*N_INIT-1:0] INIT_LEN   = {4'd10, 4'd6},
  parameter logic [5*N_BTN-1:0]  BTN_START  = {5'd20, 5'd16},
  parameter logic [4*N_BTN-1:0]  BTN_LEN    = {4'd4, 4'd4}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_rls,
  input  logic             resp_rcvd,
  output logic             send,
  output logic [4:0]       cmd_start,
  output logic [3:0]       cmd_len,
  output logic             cmd_n,
  output logic             ready,
  output logic             err,
  output logic             drop
);

  typedef enum logic [2:0] {PWRUP, BANNER, ISSUE, WRESP, IDLE, ERR} state_t;

  localparam logic [2:0] MAX_R     = 3'(MAX_RETRY);
  localparam logic [2:0] LAST_INIT = 3'(N_INIT - 1);

  state_t            state;
  logic [WAIT_W-1:0] pwr_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [2:0]        idx;
  logic [2:0]        retry;
  logic              from_btn;

  logic [2:0] btn_sel;
  logic       btn_found;
  logic       btn_extra;

  function automatic logic [4:0] start_of(input logic btn, input logic [2:0] i);
    if (btn) return BTN_START[5*int'(i) +: 5];
    else     return INIT_START[5*int'(i) +: 5];
  endfunction

  function automatic logic [3:0] len_of(input logic btn, input logic [2:0] i);
    if (btn) return BTN_LEN[4*int'(i) +: 4];
    else     return INIT_LEN[4*int'(i) +: 4];
  endfunction

  // Lowest set channel wins; any further set bit is reported as discarded.
  always_comb begin
    btn_sel   = 3'd0;
    btn_found = 1'b0;
    btn_extra = 1'b0;
    for (int i = 0; i < N_BTN; i++) begin
      if (btn_rls[i]) begin
        if (btn_found) begin
          btn_extra = 1'b1;
        end else begin
          btn_sel   = 3'(i);
          btn_found = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= PWRUP;
      pwr_cnt   <= '0;
      tmo_cnt   <= '0;
      idx       <= 3'd0;
      retry     <= 3'd0;
      from_btn  <= 1'b0;
      send      <= 1'b0;
      cmd_start <= 5'd0;
      cmd_len   <= 4'd0;
      cmd_n     <= 1'b1;
      ready     <= 1'b0;
      err       <= 1'b0;
      drop      <= 1'b0;
    end else begin
      send      <= 1'b0;
      cmd_start <= 5'd0;
      cmd_len   <= 4'd0;
      drop      <= (state == IDLE) ? btn_extra : btn_found;

      case (state)
        PWRUP: begin
          if (&pwr_cnt) begin
            state   <= BANNER;
            cmd_n   <= 1'b0;
            tmo_cnt <= '0;
          end else begin
            pwr_cnt <= pwr_cnt + WAIT_W'(1);
          end
        end
        BANNER: begin
          if (resp_rcvd) begin
            state     <= ISSUE;
            idx       <= 3'd0;
            from_btn  <= 1'b0;
            send      <= 1'b1;
            cmd_start <= start_of(1'b0, 3'd0);
            cmd_len   <= len_of(1'b0, 3'd0);
          end else if (&tmo_cnt) begin
            state <= ERR;
            err   <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        ISSUE: begin
          tmo_cnt <= '0;
          state   <= WRESP;
        end
        WRESP: begin
          // A response arriving on the timeout cycle still counts.
          if (resp_rcvd) begin
            retry <= 3'd0;
            if (!from_btn && idx < LAST_INIT) begin
              idx       <= idx + 3'd1;
              state     <= ISSUE;
              send      <= 1'b1;
              cmd_start <= start_of(1'b0, idx + 3'd1);
              cmd_len   <= len_of(1'b0, idx + 3'd1);
            end else begin
              state <= IDLE;
              ready <= 1'b1;
            end
          end else if (&tmo_cnt) begin
            if (retry < MAX_R) begin
              retry     <= retry + 3'd1;
              state     <= ISSUE;
              send      <= 1'b1;
              cmd_start <= start_of(from_btn, idx);
              cmd_len   <= len_of(from_btn, idx);
            end else begin
              state <= ERR;
              err   <= 1'b1;
            end
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        IDLE: begin
          if (btn_found) begin
            from_btn  <= 1'b1;
            idx       <= btn_sel;
            state     <= ISSUE;
            ready     <= 1'b0;
            send      <= 1'b1;
            cmd_start <= start_of(1'b1, btn_sel);
            cmd_len   <= len_of(1'b1, btn_sel);
          end
        end
        ERR: begin
          state <= ERR;
        end
        default: begin
          state <= PWRUP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bt_cmd_seq.sv
// tb/tb_bt_cmd_seq.sv - directed bench for bt_cmd_seq (WAIT_W=4, TMO_W=6) plus a 4-button build.
module tb_bt_cmd_seq;

  logic       clk;
  logic       rst;
  logic [1:0] btn_rls;
  logic [3:0] btn4;
  logic       resp_rcvd;

  logic       send, cmd_n, ready, err, drop;
  logic [4:0] cmd_start;
  logic [3:0] cmd_len;
  logic       send4, cmd_n4, ready4, err4, drop4;
  logic [4:0] cmd_start4;
  logic [3:0] cmd_len4;

  int vec;
  int errs;

  bt_cmd_seq #(.WAIT_W(4), .TMO_W(6)) dut (
    .clk(clk), .rst(rst), .btn_rls(btn_rls), .resp_rcvd(resp_rcvd),
    .send(send), .cmd_start(cmd_start), .cmd_len(cmd_len),
    .cmd_n(cmd_n), .ready(ready), .err(err), .drop(drop)
  );

  bt_cmd_seq #(
    .WAIT_W(4), .TMO_W(6), .N_BTN(4),
    .BTN_START({5'd28, 5'd24, 5'd20, 5'd16}),
    .BTN_LEN({4'd7, 4'd3, 4'd4, 4'd4})
  ) dut4 (
    .clk(clk), .rst(rst), .btn_rls(btn4), .resp_rcvd(resp_rcvd),
    .send(send4), .cmd_start(cmd_start4), .cmd_len(cmd_len4),
    .cmd_n(cmd_n4), .ready(ready4), .err(err4), .drop(drop4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_resp;
    resp_rcvd = 1'b1;
    tick();
    resp_rcvd = 1'b0;
  endtask

  task automatic bring_to_idle;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (16) tick();
    pulse_resp();
    tick();
    pulse_resp();
    tick();
    pulse_resp();
  endtask

  task automatic test_reset;
    rst = 1'b1; btn_rls = 2'b11; btn4 = 4'b1111; resp_rcvd = 1'b1;
    tick();
    tick();
    btn_rls = 2'b00; btn4 = 4'b0000; resp_rcvd = 1'b0;
    vec++;
    if ({send, cmd_start, cmd_len, cmd_n, ready, err, drop} !== {1'b0, 5'd0, 4'd0, 1'b1, 3'b000}) begin
      errs++;
      $display("FAIL reset_outputs: got %h expected %h", {send, cmd_start, cmd_len, cmd_n, ready, err, drop}, {1'b0, 5'd0, 4'd0, 1'b1, 3'b000});
    end
  endtask

  task automatic test_power_up;
    int n_hi = 0;
    int n_send = 0;
    rst = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (cmd_n === 1'b1) n_hi++;
      if (send === 1'b1) n_send++;
    end
    vec++;
    if (n_hi !== 15) begin errs++; $display("FAIL pwrup_cmd_n_high: got %0d cycles expected 15", n_hi); end
    tick();
    vec++;
    if (cmd_n !== 1'b0) begin errs++; $display("FAIL pwrup_cmd_n_fall: got %b expected 0", cmd_n); end
    repeat (5) begin
      tick();
      if (send === 1'b1) n_send++;
    end
    vec++;
    if (n_send !== 0 || ready !== 1'b0) begin
      errs++; $display("FAIL pwrup_no_send: got sends=%0d ready=%b expected 0/0", n_send, ready);
    end
  endtask

  task automatic test_init_seq;
    pulse_resp();
    vec++;
    if ({send, cmd_start, cmd_len} !== {1'b1, 5'd0, 4'd6}) begin
      errs++; $display("FAIL init0_send: got %b/%0d/%0d expected 1/0/6", send, cmd_start, cmd_len);
    end
    tick();
    vec++;
    if ({send, cmd_start, cmd_len} !== 10'd0) begin
      errs++; $display("FAIL init0_one_cycle: got %b/%0d/%0d expected 0/0/0", send, cmd_start, cmd_len);
    end
    pulse_resp();
    vec++;
    if ({send, cmd_start, cmd_len} !== {1'b1, 5'd6, 4'd10}) begin
      errs++; $display("FAIL init1_send: got %b/%0d/%0d expected 1/6/10", send, cmd_start, cmd_len);
    end
    tick();
    vec++;
    if (ready !== 1'b0) begin errs++; $display("FAIL init_not_ready: got %b expected 0", ready); end
    pulse_resp();
    vec++;
    if (ready !== 1'b1 || send !== 1'b0) begin
      errs++; $display("FAIL init_ready: got ready=%b send=%b expected 1/0", ready, send);
    end
  endtask

  task automatic test_btn_multi;
    int n = 0;
    int d = 0;
    btn_rls = 2'b11;
    tick();
    btn_rls = 2'b00;
    vec++;
    if ({send, cmd_start, cmd_len} !== {1'b1, 5'd16, 4'd4}) begin
      errs++; $display("FAIL btn11_send: got %b/%0d/%0d expected 1/16/4", send, cmd_start, cmd_len);
    end
    vec++;
    if (drop !== 1'b1 || ready !== 1'b0) begin
      errs++; $display("FAIL btn11_drop: got drop=%b ready=%b expected 1/0", drop, ready);
    end
    repeat (4) begin
      tick();
      if (send === 1'b1) n++;
      if (drop === 1'b1) d++;
    end
    vec++;
    if (n !== 0 || d !== 0) begin errs++; $display("FAIL btn11_single: got sends=%0d drops=%0d expected 0/0", n, d); end
    pulse_resp();
    vec++;
    if (ready !== 1'b1) begin errs++; $display("FAIL btn11_ready: got %b expected 1", ready); end
    btn_rls = 2'b10;
    tick();
    btn_rls = 2'b00;
    vec++;
    if ({send, cmd_start, cmd_len, drop} !== {1'b1, 5'd20, 4'd4, 1'b0}) begin
      errs++; $display("FAIL btn10_send: got %b/%0d/%0d drop=%b expected 1/20/4 drop=0", send, cmd_start, cmd_len, drop);
    end
    tick();
    pulse_resp();
    vec++;
    if (ready !== 1'b1) begin errs++; $display("FAIL btn10_ready: got %b expected 1", ready); end
  endtask

  task automatic test_resp_at_timeout;
    int n = 0;
    btn_rls = 2'b01;
    tick();
    btn_rls = 2'b00;
    vec++;
    if (send !== 1'b1) begin errs++; $display("FAIL tmo_edge_send: got %b expected 1", send); end
    repeat (64) begin
      tick();
      if (send === 1'b1) n++;
    end
    vec++;
    if (n !== 0 || ready !== 1'b0) begin
      errs++; $display("FAIL tmo_edge_wait: got sends=%0d ready=%b expected 0/0", n, ready);
    end
    resp_rcvd = 1'b1;
    tick();
    resp_rcvd = 1'b0;
    vec++;
    if (ready !== 1'b1 || send !== 1'b0) begin
      errs++; $display("FAIL tmo_edge_resp_wins: got ready=%b send=%b expected 1/0", ready, send);
    end
  endtask

  task automatic test_drop_wresp;
    int n = 0;
    btn_rls = 2'b01;
    tick();
    btn_rls = 2'b00;
    tick();
    btn_rls = 2'b10;
    tick();
    btn_rls = 2'b00;
    vec++;
    if (drop !== 1'b1 || send !== 1'b0) begin
      errs++; $display("FAIL wresp_drop: got drop=%b send=%b expected 1/0", drop, send);
    end
    repeat (3) begin
      tick();
      if (send === 1'b1) n++;
    end
    vec++;
    if (n !== 0 || drop !== 1'b0) begin
      errs++; $display("FAIL wresp_no_queue: got sends=%0d drop=%b expected 0/0", n, drop);
    end
    rst = 1'b1;
    tick();
    vec++;
    if ({send, cmd_start, cmd_len, cmd_n, ready, err, drop} !== {1'b0, 5'd0, 4'd0, 1'b1, 3'b000}) begin
      errs++;
      $display("FAIL wresp_reset: got %h expected %h", {send, cmd_start, cmd_len, cmd_n, ready, err, drop}, {1'b0, 5'd0, 4'd0, 1'b1, 3'b000});
    end
  endtask

  task automatic test_reset_abort;
    int n = 0;
    rst = 1'b0;
    resp_rcvd = 1'b1;
    repeat (16) begin
      tick();
      if (send === 1'b1) n++;
    end
    resp_rcvd = 1'b0;
    repeat (3) begin
      tick();
      if (send === 1'b1) n++;
    end
    vec++;
    if (n !== 0 || cmd_n !== 1'b0) begin
      errs++; $display("FAIL abort_no_send: got sends=%0d cmd_n=%b expected 0/0", n, cmd_n);
    end
    pulse_resp();
    vec++;
    if ({send, cmd_start, cmd_len} !== {1'b1, 5'd0, 4'd6}) begin
      errs++; $display("FAIL abort_restart: got %b/%0d/%0d expected 1/0/6", send, cmd_start, cmd_len);
    end
  endtask

  task automatic test_n_btn4;
    bring_to_idle();
    vec++;
    if (ready !== 1'b1 || ready4 !== 1'b1) begin
      errs++; $display("FAIL btn4_idle: got ready=%b ready4=%b expected 1/1", ready, ready4);
    end
    btn4 = 4'b1000;
    tick();
    btn4 = 4'b0000;
    vec++;
    if ({send4, cmd_start4, cmd_len4, drop4} !== {1'b1, 5'd28, 4'd7, 1'b0}) begin
      errs++; $display("FAIL btn4_ch3: got %b/%0d/%0d drop=%b expected 1/28/7 drop=0", send4, cmd_start4, cmd_len4, drop4);
    end
    vec++;
    if (send !== 1'b0) begin errs++; $display("FAIL btn4_isolated: got %b expected 0", send); end
    tick();
    pulse_resp();
    btn4 = 4'b0110;
    tick();
    btn4 = 4'b0000;
    vec++;
    if ({send4, cmd_start4, cmd_len4, drop4} !== {1'b1, 5'd20, 4'd4, 1'b1}) begin
      errs++; $display("FAIL btn4_ch1: got %b/%0d/%0d drop=%b expected 1/20/4 drop=1", send4, cmd_start4, cmd_len4, drop4);
    end
  endtask

  task automatic test_banner_timeout;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (79) tick();
    vec++;
    if (err !== 1'b0 || cmd_n !== 1'b0) begin
      errs++; $display("FAIL banner_before_tmo: got err=%b cmd_n=%b expected 0/0", err, cmd_n);
    end
    tick();
    vec++;
    if ({err, ready, send} !== 3'b100) begin
      errs++; $display("FAIL banner_tmo_err: got err/ready/send=%b expected 100", {err, ready, send});
    end
  endtask

  task automatic test_retry_exhaust;
    int nsend = 0;
    int t0 = -1;
    int t1 = -1;
    int err_at = -1;
    int bad = 0;
    int rdy_bad = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (16) tick();
    pulse_resp();
    tick();
    pulse_resp();
    vec++;
    if ({send, cmd_start, cmd_len} !== {1'b1, 5'd6, 4'd10}) begin
      errs++; $display("FAIL retry_first: got %b/%0d/%0d expected 1/6/10", send, cmd_start, cmd_len);
    end
    for (int c = 1; c <= 260; c++) begin
      tick();
      if (send === 1'b1) begin
        nsend++;
        if (nsend == 1) t0 = c;
        if (nsend == 2) t1 = c;
        if (cmd_start !== 5'd6 || cmd_len !== 4'd10) bad++;
      end
      if (err === 1'b1 && err_at < 0) err_at = c;
      if (err_at >= 0 && ready !== 1'b0) rdy_bad++;
    end
    vec++;
    if (nsend !== 2 || bad !== 0) begin
      errs++; $display("FAIL retry_count: got resends=%0d badentry=%0d expected 2/0", nsend, bad);
    end
    vec++;
    if (t0 !== 65 || t1 !== 130) begin
      errs++; $display("FAIL retry_spacing: got %0d,%0d expected 65,130", t0, t1);
    end
    vec++;
    if (err_at !== 195) begin errs++; $display("FAIL retry_err_time: got %0d expected 195", err_at); end
    vec++;
    if (rdy_bad !== 0 || err !== 1'b1) begin
      errs++; $display("FAIL retry_err_sticky: got ready_hits=%0d err=%b expected 0/1", rdy_bad, err);
    end
    btn_rls = 2'b01;
    tick();
    btn_rls = 2'b00;
    vec++;
    if ({drop, send, err, ready} !== 4'b1010) begin
      errs++; $display("FAIL err_btn_drop: got drop/send/err/ready=%b expected 1010", {drop, send, err, ready});
    end
  endtask

  initial begin
    vec = 0;
    errs = 0;
    rst = 1'b1;
    btn_rls = 2'b00;
    btn4 = 4'b0000;
    resp_rcvd = 1'b0;
    test_reset();
    test_power_up();
    test_init_seq();
    test_btn_multi();
    test_resp_at_timeout();
    test_drop_wresp();
    test_reset_abort();
    test_n_btn4();
    test_banner_timeout();
    test_retry_exhaust();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
